// File: rtl/aurora_enc_packer.sv
// aurora_enc_packer: frames encoder samples onto Aurora AXI4-Stream as start/stop command
// frames around fixed-length data frames, buffering samples in an internal sync FIFO.
module aurora_enc_packer #(
    parameter int DATA_WD    = 64,
    parameter int PKT_LEN    = 32,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_rst,
    input  logic                 enc_start,
    input  logic                 enc_stop,
    input  logic                 enc_vld,
    input  logic [DATA_WD-1:0]   enc_data,
    output logic [DATA_WD-1:0]   m_axis_tdata,
    output logic [DATA_WD/8-1:0] m_axis_tkeep,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 busy,
    output logic                 ovf,
    output logic [15:0]          frm_cnt,
    output logic [31:0]          drop_cnt,
    output logic [2:0]           dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DATA_WD-1:0] CMD_SYNC  = DATA_WD'(32'h55AA_0001);
    localparam logic [DATA_WD-1:0] CMD_START = DATA_WD'(32'h0000_0004);
    localparam logic [DATA_WD-1:0] CMD_STOP  = DATA_WD'(32'h0000_0005);

    typedef enum logic [2:0] {
        IDLE, S_HDR, S_CMD, CAPT, D_HDR, D_PAY, P_HDR, P_CMD
    } state_t;

    state_t             r_state;
    logic [DATA_WD-1:0] r_tdata;
    logic               r_tvalid;
    logic               r_tlast;
    logic               r_stop_pend;
    logic               r_win;
    logic               r_ovf;
    logic [15:0]        r_frm_cnt;
    logic [31:0]        r_drop_cnt;
    logic [7:0]         r_len;
    logic [7:0]         r_beat;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_fifo_cnt;
    logic [DATA_WD-1:0] r_mem [FIFO_DEPTH];

    logic               w_hs;
    logic               w_full;
    logic               w_wr;
    logic               w_drop;
    logic               w_rd;
    logic [7:0]         w_cap_len;
    logic [DATA_WD-1:0] w_rd_data;

    // A beat completes on tvalid & tready; once tvalid is raised, tdata/tlast/tvalid are
    // only changed in the handshake cycle (or by cfg_rst, which aborts the frame).
    assign w_hs      = r_tvalid & m_axis_tready;
    assign w_full    = (r_fifo_cnt == CW'(FIFO_DEPTH));
    assign w_wr      = r_win & enc_vld & ~w_full & ~cfg_rst;
    assign w_drop    = r_win & enc_vld & w_full;
    assign w_rd_data = r_mem[r_rd_ptr];

    always_comb begin
        w_rd      = 1'b0;
        w_cap_len = 8'(PKT_LEN);
        if (w_hs && (r_state == D_HDR || (r_state == D_PAY && !r_tlast)))
            w_rd = 1'b1;
        if (r_fifo_cnt < CW'(PKT_LEN))
            w_cap_len = 8'(r_fifo_cnt);
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= enc_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_win       <= 1'b0;
            r_ovf       <= 1'b0;
            r_frm_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
        end else if (cfg_rst) begin
            r_state     <= IDLE;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_win       <= 1'b0;
            r_ovf       <= 1'b0;
            r_frm_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_rd)
                r_fifo_cnt <= r_fifo_cnt + 1'b1;
            else if (!w_wr && w_rd)
                r_fifo_cnt <= r_fifo_cnt - 1'b1;

            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop_cnt != '1)
                    r_drop_cnt <= r_drop_cnt + 32'd1;
            end

            if (enc_stop)
                r_win <= 1'b0;
            if (enc_stop && r_state != IDLE && r_state != P_HDR && r_state != P_CMD)
                r_stop_pend <= 1'b1;

            unique case (r_state)
                IDLE: begin
                    if (enc_start) begin
                        r_state     <= S_HDR;
                        r_tvalid    <= 1'b1;
                        r_tdata     <= CMD_SYNC;
                        r_tlast     <= 1'b0;
                        r_stop_pend <= enc_stop;
                    end
                end
                S_HDR: begin
                    if (w_hs) begin
                        r_state <= S_CMD;
                        r_tdata <= CMD_START;
                        r_tlast <= 1'b1;
                    end
                end
                S_CMD: begin
                    if (w_hs) begin
                        r_state  <= CAPT;
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        // A stop seen before the window opens leaves it closed.
                        r_win    <= ~r_stop_pend & ~enc_stop;
                    end
                end
                CAPT: begin
                    if (r_fifo_cnt >= CW'(PKT_LEN) || (r_stop_pend && r_fifo_cnt != '0)) begin
                        r_state  <= D_HDR;
                        r_len    <= w_cap_len;
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b0;
                        r_tdata  <= DATA_WD'({16'h0, r_frm_cnt, 8'h0, w_cap_len, 8'h0});
                    end else if (r_stop_pend) begin
                        r_state     <= P_HDR;
                        r_stop_pend <= 1'b0;
                        r_tvalid    <= 1'b1;
                        r_tlast     <= 1'b0;
                        r_tdata     <= CMD_SYNC;
                    end
                end
                D_HDR: begin
                    if (w_hs) begin
                        r_state <= D_PAY;
                        r_tdata <= w_rd_data;
                        r_beat  <= 8'd1;
                        r_tlast <= (r_len == 8'd1);
                    end
                end
                D_PAY: begin
                    if (w_hs) begin
                        if (r_tlast) begin
                            r_state   <= CAPT;
                            r_tvalid  <= 1'b0;
                            r_tlast   <= 1'b0;
                            r_frm_cnt <= r_frm_cnt + 16'd1;
                        end else begin
                            r_tdata <= w_rd_data;
                            r_beat  <= r_beat + 8'd1;
                            r_tlast <= (r_beat + 8'd1 == r_len);
                        end
                    end
                end
                P_HDR: begin
                    if (w_hs) begin
                        r_state <= P_CMD;
                        r_tdata <= CMD_STOP;
                        r_tlast <= 1'b1;
                    end
                end
                P_CMD: begin
                    if (w_hs) begin
                        r_state  <= IDLE;
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = '1;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = (r_state != IDLE);
    assign ovf           = r_ovf;
    assign frm_cnt       = r_frm_cnt;
    assign drop_cnt      = r_drop_cnt;
    assign dbg_state     = r_state;

endmodule
